single_macc_sample_tx: RTL and testbench

SINGLE_MACC_SAMPLE_TX -- requirements
Module: single_macc_sample_tx

---
 rtl/single_macc_sample_tx.sv | 105 ++++++++++
 tb/tb_single_macc_sample_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_macc_sample_tx.sv
// Sample pacer for a single-MACC FIR: buffers upstream samples in a small FIFO and
// presents one sample with a new-data strobe every PERIOD clocks.
module single_macc_sample_tx #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned PERIOD = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     Clk_i,
    input  logic                     Rst_i,
    input  logic                     Enable_i,
    input  logic                     ClrFlags_i,
    input  logic [DATA_W-1:0]        Data_i,
    input  logic                     DataValid_i,
    output logic                     Ready_o,
    output logic [DATA_W-1:0]        Data_o,
    output logic                     DataNd_o,
    output logic [$clog2(DEPTH):0]   Level_o,
    output logic                     Overflow_o,
    output logic                     Underrun_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wrPtrQ, wrPtrD;
    logic [AW-1:0]     rdPtrQ, rdPtrD;
    logic [LW-1:0]     levelQ, levelD;
    logic [CW-1:0]     slotCntQ, slotCntD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic              dataNdQ;
    logic              overflowQ, overflowD;
    logic              underrunQ, underrunD;

    logic full, empty, slot, push, pop, overflowSet, underrunSet;

    always_comb begin
        full        = (levelQ == LW'(DEPTH));
        empty       = (levelQ == '0);
        slot        = Enable_i && (slotCntQ == '0);
        push        = DataValid_i && !full;
        // Pop decision uses the pre-edge level, so a push landing on an empty
        // FIFO at a slot edge is not visible to that slot.
        pop         = slot && !empty;
        overflowSet = DataValid_i && full;
        underrunSet = slot && empty;

        slotCntD = '0;
        if (Enable_i && (slotCntQ != CW'(PERIOD - 1))) begin
            slotCntD = slotCntQ + 1'b1;
        end

        wrPtrD = push ? wrPtrQ + 1'b1 : wrPtrQ;
        rdPtrD = pop  ? rdPtrQ + 1'b1 : rdPtrQ;
        levelD = levelQ + LW'(push) - LW'(pop);

        dataD = dataQ;
        if (slot) begin
            dataD = pop ? mem[rdPtrQ] : '0;
        end

        // Set events win over a same-cycle clear.
        overflowD = overflowSet || (overflowQ && !ClrFlags_i);
        underrunD = underrunSet || (underrunQ && !ClrFlags_i);
    end

    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            levelQ    <= '0;
            slotCntQ  <= '0;
            dataQ     <= '0;
            dataNdQ   <= 1'b0;
            overflowQ <= 1'b0;
            underrunQ <= 1'b0;
        end else begin
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            levelQ    <= levelD;
            slotCntQ  <= slotCntD;
            dataQ     <= dataD;
            dataNdQ   <= slot;
            overflowQ <= overflowD;
            underrunQ <= underrunD;
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge Clk_i) begin
        if (Rst_i && push) begin
            mem[wrPtrQ] <= Data_i;
        end
    end

    assign Ready_o    = !full;
    assign Level_o    = levelQ;
    assign Data_o     = dataQ;
    assign DataNd_o   = dataNdQ;
    assign Overflow_o = overflowQ;
    assign Underrun_o = underrunQ;

endmodule

// File: tb/tb_single_macc_sample_tx.sv
// Self-checking bench for single_macc_sample_tx: directed tables and sequences plus
// random traffic against a queue-based reference model.
module tb_single_macc_sample_tx;

    localparam int DATA_W = 18;
    localparam int PERIOD = 16;
    localparam int DEPTH  = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              Clk_i = 1'b0;
    logic              Rst_i;
    logic              Enable_i;
    logic              ClrFlags_i;
    logic [DATA_W-1:0] Data_i;
    logic              DataValid_i;
    logic              Ready_o;
    logic [DATA_W-1:0] Data_o;
    logic              DataNd_o;
    logic [LW-1:0]     Level_o;
    logic              Overflow_o;
    logic              Underrun_o;

    single_macc_sample_tx #(
        .DATA_W (DATA_W),
        .PERIOD (PERIOD),
        .DEPTH  (DEPTH)
    ) dut (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .Enable_i    (Enable_i),
        .ClrFlags_i  (ClrFlags_i),
        .Data_i      (Data_i),
        .DataValid_i (DataValid_i),
        .Ready_o     (Ready_o),
        .Data_o      (Data_o),
        .DataNd_o    (DataNd_o),
        .Level_o     (Level_o),
        .Overflow_o  (Overflow_o),
        .Underrun_o  (Underrun_o)
    );

    always #5 Clk_i = ~Clk_i;

    int nCmp = 0;
    int nBad = 0;
    int cyc  = 0;
    int maxLvl = 0;

    // Reference model: a sample queue, a slot phase and the two sticky flags.
    logic [DATA_W-1:0] mq[$];
    int                mPhase = 0;
    logic [DATA_W-1:0] mData  = '0;
    logic              mNd    = 1'b0;
    logic              mOvf   = 1'b0;
    logic              mUnd   = 1'b0;

    logic [DATA_W-1:0] strobeData[$];
    int                strobeCyc[$];

    typedef struct {
        bit                en;
        bit                clr;
        bit                dv;
        logic [DATA_W-1:0] d;
        logic [LW-1:0]     expLevel;
        bit                expReady;
        bit                expOvf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit en, input bit clr, input bit dv, input logic [DATA_W-1:0] d);
        Enable_i    = en;
        ClrFlags_i  = clr;
        DataValid_i = dv;
        Data_i      = d;
    endtask

    task automatic modelEdge();
        bit slotNow, fullBefore, emptyBefore, ovfSet, undSet;
        if (!Rst_i) begin
            mq.delete();
            mPhase = 0;
            mData  = '0;
            mNd    = 1'b0;
            mOvf   = 1'b0;
            mUnd   = 1'b0;
        end else begin
            fullBefore  = (mq.size() == DEPTH);
            emptyBefore = (mq.size() == 0);
            slotNow     = Enable_i && (mPhase == 0);
            ovfSet      = DataValid_i && fullBefore;
            undSet      = slotNow && emptyBefore;
            if (slotNow) mData = emptyBefore ? '0 : mq.pop_front();
            if (DataValid_i && !fullBefore) mq.push_back(Data_i);
            mNd    = slotNow;
            mOvf   = ovfSet || (mOvf && !ClrFlags_i);
            mUnd   = undSet || (mUnd && !ClrFlags_i);
            mPhase = Enable_i ? (mPhase + 1) % PERIOD : 0;
        end
    endtask

    task automatic step();
        logic          expReady;
        logic [LW-1:0] expLevel;
        modelEdge();
        expReady = (mq.size() != DEPTH);
        expLevel = LW'(mq.size());
        @(posedge Clk_i);
        #1;
        cyc++;
        check("model", {Ready_o, Level_o, Data_o, DataNd_o, Overflow_o, Underrun_o},
              {expReady, expLevel, mData, mNd, mOvf, mUnd});
        if (DataNd_o) begin
            strobeData.push_back(Data_o);
            strobeCyc.push_back(cyc);
        end
        if (int'(Level_o) > maxLvl) maxLvl = int'(Level_o);
    endtask

    task automatic runUntilPhase(input int p);
        int n = 0;
        while (mPhase != p && n < 2 * PERIOD) begin
            step();
            n++;
        end
        if (mPhase != p) check("phase_timeout", 64'(mPhase), 64'(p));
    endtask

    initial begin
        logic [DATA_W-1:0] exp38[$];
        logic [DATA_W-1:0] v;
        int                enCyc;
        int                prob;

        tbl = '{
            '{0, 0, 1, 18'd100, 4'd1, 1, 0},
            '{0, 0, 1, 18'd101, 4'd2, 1, 0},
            '{0, 0, 1, 18'd102, 4'd3, 1, 0},
            '{0, 0, 1, 18'd103, 4'd4, 1, 0},
            '{0, 0, 1, 18'd104, 4'd5, 1, 0},
            '{0, 0, 1, 18'd105, 4'd6, 1, 0},
            '{0, 0, 1, 18'd106, 4'd7, 1, 0},
            '{0, 0, 1, 18'd107, 4'd8, 0, 0},
            '{0, 0, 1, 18'd108, 4'd8, 0, 1},
            '{0, 1, 0, 18'd0,   4'd8, 0, 0}
        };

        // Reset, with a push attempted in the same cycle.
        Rst_i = 1'b0;
        drive(1, 0, 1, 18'd55);
        step();
        Rst_i = 1'b1;
        check("rst_level", Level_o, 0);
        check("rst_ready", Ready_o, 1);
        check("rst_outs", {Data_o, DataNd_o, Overflow_o, Underrun_o}, 0);

        // Three samples, then the paced strobes and underrun.
        drive(0, 0, 1, 18'd3);      step();
        drive(0, 0, 1, 18'h3FFFB);  step();
        drive(0, 0, 1, 18'd131071); step();
        drive(1, 0, 0, 18'd0);
        strobeData.delete();
        strobeCyc.delete();
        enCyc = cyc + 1;
        repeat (4 * PERIOD) step();
        check("r35_count", strobeData.size(), 4);
        if (strobeData.size() >= 4) begin
            check("r35_first_latency", strobeCyc[0], enCyc);
            check("r35_s0", strobeData[0], 18'd3);
            check("r35_s1", strobeData[1], 18'h3FFFB);
            check("r35_s2", strobeData[2], 18'd131071);
            check("r35_s3", strobeData[3], 18'd0);
            for (int i = 1; i < 4; i++) begin
                check("r35_spacing", strobeCyc[i] - strobeCyc[i-1], PERIOD);
            end
        end
        check("r35_underrun", Underrun_o, 1);

        // Fill while disabled, overflow on the ninth word, then drain in order.
        Rst_i = 1'b0; drive(0, 0, 0, 18'd0); step(); Rst_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].dv, tbl[i].d);
            step();
            check("tbl_level", Level_o, tbl[i].expLevel);
            check("tbl_ready", Ready_o, tbl[i].expReady);
            check("tbl_ovf", Overflow_o, tbl[i].expOvf);
        end
        drive(1, 0, 0, 18'd0);
        strobeData.delete();
        repeat (8 * PERIOD) step();
        check("r36_count", strobeData.size(), 8);
        for (int i = 0; i < 8 && i < strobeData.size(); i++) begin
            check("r36_order", strobeData[i], 64'(100 + i));
        end

        // Push coincident with a slot on an empty FIFO.
        runUntilPhase(PERIOD - 1);
        drive(1, 1, 0, 18'd0);
        step();
        check("r37_clr", Underrun_o, 0);
        drive(1, 0, 1, 18'd77);
        step();
        drive(1, 0, 0, 18'd0);
        check("r37_first", {DataNd_o, Data_o, Underrun_o, Level_o}, {1'b1, 18'd0, 1'b1, 4'd1});
        repeat (PERIOD - 1) step();
        check("r37_gap", DataNd_o, 0);
        step();
        check("r37_second", {DataNd_o, Data_o, Level_o}, {1'b1, 18'd77, 4'd0});

        // Steady one-in/one-out flow across many pointer wraps.
        for (int s = 0; s < 40; s++) begin
            runUntilPhase(1);
            v = DATA_W'($urandom);
            exp38.push_back(v);
            drive(1, s == 0, 1, v);
            step();
            drive(1, 0, 0, 18'd0);
            if (s == 0) begin
                strobeData.delete();
                maxLvl = 0;
            end
        end
        runUntilPhase(1);
        check("r38_underrun", Underrun_o, 0);
        check("r38_maxlevel_le1", maxLvl <= 1, 1);
        check("r38_count", strobeData.size(), 40);
        for (int i = 0; i < 40 && i < strobeData.size(); i++) begin
            check("r38_data", strobeData[i], exp38[i]);
        end

        // Both flags set, then cleared; then set-beats-clear.
        repeat (PERIOD) step();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, DATA_W'(200 + i));
            step();
        end
        drive(0, 0, 0, 18'd0);
        check("r40_both_set", {Overflow_o, Underrun_o}, 2'b11);
        drive(0, 1, 0, 18'd0);
        step();
        check("r40_both_clr", {Overflow_o, Underrun_o}, 2'b00);
        drive(0, 1, 1, 18'd5);
        step();
        check("r29_set_wins", {Overflow_o, Underrun_o}, 2'b10);
        drive(0, 0, 0, 18'd0);

        // Reset mid-period with a partly filled FIFO.
        Rst_i = 1'b0; step(); Rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, DATA_W'(300 + i));
            step();
        end
        drive(1, 0, 0, 18'd0);
        runUntilPhase(7);
        check("r39_pre_level", Level_o, 4);
        Rst_i = 1'b0;
        step();
        Rst_i = 1'b1;
        check("r39_level", Level_o, 0);
        check("r39_ready", Ready_o, 1);
        check("r39_outs", {Data_o, DataNd_o, Overflow_o, Underrun_o}, 0);
        drive(0, 0, 0, 18'd0);
        strobeData.delete();
        repeat (PERIOD + 2) step();
        check("r39_no_strobe", strobeData.size(), 0);

        // Random traffic under varying load.
        for (int chunk = 0; chunk < 6; chunk++) begin
            prob = (chunk % 3 == 0) ? 5 : ((chunk % 3 == 1) ? 50 : 95);
            for (int i = 0; i < 500; i++) begin
                Rst_i = ($urandom % 300) != 0;
                drive(($urandom % 16) != 0, ($urandom % 20) == 0,
                      ($urandom % 100) < prob, DATA_W'($urandom));
                step();
            end
        end
        Rst_i = 1'b1;
        drive(0, 0, 0, 18'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
